md_pkt_dispatcher: RTL



---
 rtl/md_pkt_dispatcher.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/md_pkt_dispatcher.sv
// md_pkt_dispatcher
//   Pairs each metadata word from the stage ALU with the next packet on the
//   input AXI-Stream, in order. Packets whose metadata discard bit is set are
//   dropped. All other packets are forwarded through a single output register,
//   with the ALU-chosen destination port written into the first-beat tuser.
//
//   Optional build macro: NEXT_TABLE_TAG_EN
//     When defined, first-beat m_axis_tuser[37:32] carries next_table_id
//     (metadata [255:250]). When undefined, those bits pass through unchanged.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   comp_meta_data_in/valid_in metadata word and its one-cycle strobe
//   s_axis_*                   input packet stream (tready driven here)
//   m_axis_*                   output packet stream (registered)
//   md_overflow                sticky: a metadata word arrived while FIFO full
//   pkt_fwd_cnt/pkt_drop_cnt   wrapping 32-bit packet counters
module md_pkt_dispatcher #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int META_LEN             = 256,
   parameter int MD_FIFO_DEPTH_BITS   = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [META_LEN-1:0]               comp_meta_data_in,
   input  logic                              comp_meta_data_valid_in,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic                              md_overflow,
   output logic [31:0]                       pkt_fwd_cnt,
   output logic [31:0]                       pkt_drop_cnt
);

   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW    = C_S_AXIS_TUSER_WIDTH;
   localparam int AW    = MD_FIFO_DEPTH_BITS;
   localparam int DEPTH = 1 << MD_FIFO_DEPTH_BITS;

   typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } axis_beat_t;

   state_t state, state_nxt;

   // ---------------------------------------------------------------------
   // Metadata FIFO. Storage is not reset; reset only rewinds the pointers.
   // ---------------------------------------------------------------------
   logic [META_LEN-1:0] md_mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         md_cnt;
   logic                md_push, md_pop, md_full, md_empty;
   logic [META_LEN-1:0] md_head;
   logic                md_head_unused;

   assign md_full  = (md_cnt == DEPTH[AW:0]);
   assign md_empty = (md_cnt == '0);
   // Fullness is judged before any same-cycle pop, so a full FIFO rejects
   // the word even when the FSM is popping in that cycle.
   assign md_push  = comp_meta_data_valid_in && !md_full;
   assign md_head  = md_mem[rd_ptr];
   // Only a few fields are consumed; fold the rest so they read as used.
   assign md_head_unused = ^md_head;

   always_ff @(posedge clk) begin
      if (md_push) md_mem[wr_ptr] <= comp_meta_data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         md_cnt      <= '0;
         md_overflow <= 1'b0;
      end else begin
         if (md_push) wr_ptr <= wr_ptr + 1'b1;
         if (md_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({md_push, md_pop})
            2'b10:   md_cnt <= md_cnt + 1'b1;
            2'b01:   md_cnt <= md_cnt - 1'b1;
            default: md_cnt <= md_cnt;
         endcase
         if (comp_meta_data_valid_in && md_full) md_overflow <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Packet FSM
   // ---------------------------------------------------------------------
   logic       s_acc;
   logic       fwd_acc;
   logic       first_beat;
   logic [7:0] md_cur_dst;
`ifdef NEXT_TABLE_TAG_EN
   logic [5:0] md_cur_ntid;
`endif

   assign s_acc   = s_axis_tvalid && s_axis_tready;
   assign fwd_acc = s_acc && (state == FORWARD);

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      md_pop        = 1'b0;
      case (state)
         IDLE: begin
            // The pop cycle is the per-packet bubble: tready stays low.
            if (!md_empty && s_axis_tvalid) begin
               md_pop    = 1'b1;
               state_nxt = md_head[128] ? DROP : FORWARD;
            end
         end
         FORWARD: begin
            s_axis_tready = !m_axis_tvalid || m_axis_tready;
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) state_nxt = IDLE;
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         first_beat   <= 1'b0;
         md_cur_dst   <= '0;
`ifdef NEXT_TABLE_TAG_EN
         md_cur_ntid  <= '0;
`endif
         pkt_fwd_cnt  <= '0;
         pkt_drop_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (md_pop) begin
            first_beat  <= 1'b1;
            md_cur_dst  <= md_head[31:24];
`ifdef NEXT_TABLE_TAG_EN
            md_cur_ntid <= md_head[255:250];
`endif
         end else if (s_acc) begin
            first_beat  <= 1'b0;
         end
         if (s_acc && s_axis_tlast && state == FORWARD) pkt_fwd_cnt  <= pkt_fwd_cnt + 32'd1;
         if (s_acc && s_axis_tlast && state == DROP)    pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Output register. In FORWARD, tready already guarantees the slot is free,
   // so a load never overwrites an undelivered beat. Outside FORWARD a
   // pending beat keeps draining.
   // ---------------------------------------------------------------------
   axis_beat_t beat_d, out_q;

   always_comb begin
      beat_d.data = s_axis_tdata;
      beat_d.keep = s_axis_tkeep;
      beat_d.user = s_axis_tuser;
      beat_d.last = s_axis_tlast;
      if (first_beat) begin
         beat_d.user[31:24] = md_cur_dst;
`ifdef NEXT_TABLE_TAG_EN
         beat_d.user[37:32] = md_cur_ntid;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q         <= '0;
         m_axis_tvalid <= 1'b0;
      end else if (fwd_acc) begin
         out_q         <= beat_d;
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   assign m_axis_tdata = out_q.data;
   assign m_axis_tkeep = out_q.keep;
   assign m_axis_tuser = out_q.user;
   assign m_axis_tlast = out_q.last;

endmodule
